// File: rtl/pc.sv
// Program counter at the head of the IF stage: steps by PC_STEP or takes a conditional branch.
// Optional macro PC_PLUS4_OUT_EN adds the pc_plus4 output for link-register use.
module pc #(
    parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
    parameter int unsigned PC_STEP      = 4,
    parameter int unsigned OFFSET_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SaltoCond,
    input  logic [31:0] extSigno,
    input  logic        oZero,
`ifdef PC_PLUS4_OUT_EN
    output logic [31:0] pc_plus4,
`endif
    output logic [31:0] direinstru
);

    logic [31:0] pc_q;
    logic [31:0] pc_plus;
    logic [31:0] branch_target;
    logic        taken;

    // The shift drops the top bits of extSigno; the add wraps modulo 2^32.
    always_comb begin
        pc_plus       = pc_q + PC_STEP;
        branch_target = pc_plus + (extSigno << OFFSET_SHIFT);
        taken         = SaltoCond & oZero;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_ADDR;
        end else if (taken) begin
            pc_q <= branch_target;
        end else begin
            pc_q <= pc_plus;
        end
    end

    assign direinstru = pc_q;

`ifdef PC_PLUS4_OUT_EN
    assign pc_plus4 = pc_plus;
`endif

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed cases, then random stimulus against a reference model.
module tb_pc;

    logic        clk;
    logic        reset;
    logic        SaltoCond;
    logic [31:0] extSigno;
    logic        oZero;
    logic [31:0] direinstru;
`ifdef PC_PLUS4_OUT_EN
    logic [31:0] pc_plus4;
`endif

    int checks;
    int errors;
    logic [31:0] model_pc;

    pc dut (
        .clk        (clk),
        .reset      (reset),
        .SaltoCond  (SaltoCond),
        .extSigno   (extSigno),
        .oZero      (oZero),
`ifdef PC_PLUS4_OUT_EN
        .pc_plus4   (pc_plus4),
`endif
        .direinstru (direinstru)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic applyStimulus(input string tag, input logic rst, input logic sc,
                                 input logic z, input logic [31:0] ext);
        logic [31:0] expected;
        reset     = rst;
        SaltoCond = sc;
        oZero     = z;
        extSigno  = ext;
        if (rst)
            expected = 32'h0;
        else if (sc === 1'b1 && z === 1'b1)
            expected = model_pc + 32'd4 + ext * 32'd4;
        else
            expected = model_pc + 32'd4;
        @(posedge clk);
        #1;
        model_pc = expected;
        checkOutput(tag, direinstru, model_pc);
`ifdef PC_PLUS4_OUT_EN
        checkOutput({tag, "_plus4"}, pc_plus4, model_pc + 32'd4);
`endif
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_pc  = 32'h0;
        reset     = 1'b1;
        SaltoCond = 1'b0;
        oZero     = 1'b0;
        extSigno  = 32'h0;
        #2;

        applyStimulus("reset",      1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus("seq1",       1'b0, 1'b0, 1'b0, 32'h1);
        applyStimulus("seq2",       1'b0, 1'b0, 1'b0, 32'h1);
        applyStimulus("seq3",       1'b0, 1'b0, 1'b0, 32'h1);
        applyStimulus("seq4",       1'b0, 1'b0, 1'b0, 32'h1);
        checkOutput("at_0x10", direinstru, 32'h10);
        applyStimulus("zero_only",  1'b0, 1'b0, 1'b1, 32'h1);
        checkOutput("zero_only_abs", direinstru, 32'h14);
        applyStimulus("salto_only", 1'b0, 1'b1, 1'b0, 32'h1);
        checkOutput("salto_only_abs", direinstru, 32'h18);
        applyStimulus("taken1",     1'b0, 1'b1, 1'b1, 32'h1);
        checkOutput("taken1_abs", direinstru, 32'h20);
        applyStimulus("backward",   1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        checkOutput("backward_abs", direinstru, 32'h1C);
        applyStimulus("taken2",     1'b0, 1'b1, 1'b1, 32'h2);
        checkOutput("taken2_abs", direinstru, 32'h28);
        applyStimulus("rst_prio",   1'b1, 1'b1, 1'b1, 32'h5);
        checkOutput("rst_prio_abs", direinstru, 32'h0);
        applyStimulus("rst_release",1'b0, 1'b0, 1'b0, 32'h5);
        checkOutput("rst_release_abs", direinstru, 32'h4);
        applyStimulus("rst_x",      1'b1, 1'bx, 1'bx, 32'h7);
        applyStimulus("to_top",     1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        checkOutput("to_top_abs", direinstru, 32'hFFFF_FFFC);
        applyStimulus("wrap",       1'b0, 1'b0, 1'b1, 32'h3);
        checkOutput("wrap_abs", direinstru, 32'h0);

        for (int i = 0; i < 300; i++) begin
            logic rr;
            rr = ($urandom_range(0, 15) == 0);
            applyStimulus("random", rr, 1'($urandom), 1'($urandom), $urandom);
            checkOutput("align", {30'h0, direinstru[1:0]}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
